// File: rtl/warp_issue_scoreboard_if.sv
// Issue-stage bus: instruction-buffer heads in, one registered issue slot out, writeback in.
// WARP_ISSUE_PERF_CTR_EN adds the three performance-counter outputs.
interface warp_issue_scoreboard_if #(
  parameter int ARCH_LEN  = 32,
  parameter int NUM_WARPS = 8,
  parameter int NUM_LANES = 16,
  parameter int OP_BITS   = 9,
  parameter int REG_BITS  = 8
);
  localparam int WARP_ID_BITS = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0]           ibuf_valid;
  logic [NUM_WARPS-1:0]           ibuf_ready;
  logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_pc;
  logic [NUM_WARPS*OP_BITS-1:0]   ibuf_op;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rd;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs1;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs2;
  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs3;
  logic [NUM_WARPS*NUM_LANES-1:0] ibuf_tmask;

  logic                    issue_valid;
  logic                    issue_ready;
  logic [WARP_ID_BITS-1:0] issue_wid;
  logic [ARCH_LEN-1:0]     issue_pc;
  logic [OP_BITS-1:0]      issue_op;
  logic [REG_BITS-1:0]     issue_rd;
  logic [REG_BITS-1:0]     issue_rs1;
  logic [REG_BITS-1:0]     issue_rs2;
  logic [REG_BITS-1:0]     issue_rs3;
  logic [NUM_LANES-1:0]    issue_tmask;

  logic                    wb_valid;
  logic [WARP_ID_BITS-1:0] wb_wid;
  logic [REG_BITS-1:0]     wb_rd;
  logic                    sb_empty;
`ifdef WARP_ISSUE_PERF_CTR_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_hazard_stall;
  logic [31:0] perf_backpressure;
`endif

  modport master (
    output ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_tmask,
    input  ibuf_ready,
    input  issue_valid, issue_wid, issue_pc, issue_op, issue_rd, issue_rs1, issue_rs2,
           issue_rs3, issue_tmask,
    output issue_ready, wb_valid, wb_wid, wb_rd,
    input  sb_empty
`ifdef WARP_ISSUE_PERF_CTR_EN
    , input perf_issued, perf_hazard_stall, perf_backpressure
`endif
  );

  modport slave (
    input  ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_tmask,
    output ibuf_ready,
    output issue_valid, issue_wid, issue_pc, issue_op, issue_rd, issue_rs1, issue_rs2,
           issue_rs3, issue_tmask,
    input  issue_ready, wb_valid, wb_wid, wb_rd,
    output sb_empty
`ifdef WARP_ISSUE_PERF_CTR_EN
    , output perf_issued, perf_hazard_stall, perf_backpressure
`endif
  );
endinterface

// File: rtl/warp_issue_scoreboard.sv
// Round-robin warp issue with a per-warp register scoreboard and one registered output stage.
// Optional counters: define WARP_ISSUE_PERF_CTR_EN.
module warp_issue_scoreboard #(
  parameter int ARCH_LEN  = 32,
  parameter int NUM_WARPS = 8,
  parameter int NUM_LANES = 16,
  parameter int OP_BITS   = 9,
  parameter int REG_BITS  = 8
) (
  input logic clock,
  input logic reset,
  warp_issue_scoreboard_if.slave bus
);
  localparam int WARP_ID_BITS = $clog2(NUM_WARPS);
  localparam int SB_DEPTH     = 2 ** REG_BITS;

  typedef logic [WARP_ID_BITS-1:0] wid_t;
  typedef logic [REG_BITS-1:0]     reg_t;

  logic [NUM_WARPS-1:0][SB_DEPTH-1:0] sb_q, sb_d;
  logic                 sb_empty_q;
  wid_t                 rr_q, rr_d;
  logic                 issue_valid_q, issue_valid_d;
  wid_t                 wid_q;
  logic [ARCH_LEN-1:0]  pc_q;
  logic [OP_BITS-1:0]   op_q;
  reg_t                 rd_q, rs1_q, rs2_q, rs3_q;
  logic [NUM_LANES-1:0] tmask_q;

  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] pop;
  wid_t                 scan_idx;
  wid_t                 sel;
  logic                 found, can_load, fire;
  reg_t                 sel_rd;

  // Register 0 is never tracked, so a zero field can never be a hazard.
  function automatic logic pending(input logic [SB_DEPTH-1:0] row, input reg_t r);
    return (r != '0) && row[r];
  endfunction

  always_comb begin
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = bus.ibuf_valid[w]
             && !pending(sb_q[w], bus.ibuf_rd [REG_BITS*w +: REG_BITS])
             && !pending(sb_q[w], bus.ibuf_rs1[REG_BITS*w +: REG_BITS])
             && !pending(sb_q[w], bus.ibuf_rs2[REG_BITS*w +: REG_BITS])
             && !pending(sb_q[w], bus.ibuf_rs3[REG_BITS*w +: REG_BITS]);
    end
  end

  // NUM_WARPS is a power of two, so the warp-id adder wraps modulo NUM_WARPS.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = rr_q + wid_t'(i);
      if (!found && elig[scan_idx]) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end
  end

  assign can_load = !issue_valid_q || bus.issue_ready;
  assign fire     = found && can_load && !reset;
  assign sel_rd   = bus.ibuf_rd[REG_BITS*sel +: REG_BITS];

  always_comb begin
    pop = '0;
    if (fire) pop[sel] = 1'b1;
  end

  // Set after clear so an issue and a writeback to the same register leave it pending.
  always_comb begin
    sb_d = sb_q;
    if (bus.wb_valid && bus.wb_rd != '0) sb_d[bus.wb_wid][bus.wb_rd] = 1'b0;
    if (fire && sel_rd != '0) sb_d[sel][sel_rd] = 1'b1;
  end

  assign rr_d          = fire ? sel + wid_t'(1) : rr_q;
  assign issue_valid_d = fire ? 1'b1 : (bus.issue_ready ? 1'b0 : issue_valid_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_q          <= '0;
      sb_empty_q    <= 1'b1;
      rr_q          <= '0;
      issue_valid_q <= 1'b0;
      wid_q         <= '0;
      pc_q          <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rs3_q         <= '0;
      tmask_q       <= '0;
    end else begin
      sb_q          <= sb_d;
      sb_empty_q    <= ~|sb_d;
      rr_q          <= rr_d;
      issue_valid_q <= issue_valid_d;
      if (fire) begin
        wid_q   <= sel;
        pc_q    <= bus.ibuf_pc   [ARCH_LEN*sel  +: ARCH_LEN];
        op_q    <= bus.ibuf_op   [OP_BITS*sel   +: OP_BITS];
        rd_q    <= sel_rd;
        rs1_q   <= bus.ibuf_rs1  [REG_BITS*sel  +: REG_BITS];
        rs2_q   <= bus.ibuf_rs2  [REG_BITS*sel  +: REG_BITS];
        rs3_q   <= bus.ibuf_rs3  [REG_BITS*sel  +: REG_BITS];
        tmask_q <= bus.ibuf_tmask[NUM_LANES*sel +: NUM_LANES];
      end
    end
  end

  assign bus.ibuf_ready  = pop;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_wid   = wid_q;
  assign bus.issue_pc    = pc_q;
  assign bus.issue_op    = op_q;
  assign bus.issue_rd    = rd_q;
  assign bus.issue_rs1   = rs1_q;
  assign bus.issue_rs2   = rs2_q;
  assign bus.issue_rs3   = rs3_q;
  assign bus.issue_tmask = tmask_q;
  assign bus.sb_empty    = sb_empty_q;

`ifdef WARP_ISSUE_PERF_CTR_EN
  logic [31:0] perf_issued_q, perf_hazard_q, perf_bp_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_hazard_q <= '0;
      perf_bp_q     <= '0;
    end else begin
      if (fire) perf_issued_q <= perf_issued_q + 32'd1;
      if (|bus.ibuf_valid && !found && can_load) perf_hazard_q <= perf_hazard_q + 32'd1;
      if (issue_valid_q && !bus.issue_ready) perf_bp_q <= perf_bp_q + 32'd1;
    end
  end

  assign bus.perf_issued       = perf_issued_q;
  assign bus.perf_hazard_stall = perf_hazard_q;
  assign bus.perf_backpressure = perf_bp_q;
`endif
endmodule

// File: tb/tb_warp_issue_scoreboard.sv
// Directed plus random bench for warp_issue_scoreboard against a pending-set reference model.
module tb_warp_issue_scoreboard;
  localparam int NW = 8;
  localparam int AL = 32;
  localparam int NL = 16;
  localparam int OB = 9;
  localparam int RB = 8;

  logic clock;
  logic reset;

  warp_issue_scoreboard_if bus ();
  warp_issue_scoreboard dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: set of pending registers per warp, round-robin start, output slot contents.
  bit          m_pend [NW][1 << RB];
  int          m_rr;
  bit          m_iv;
  int          m_wid;
  logic [AL-1:0] m_pc;
  logic [OB-1:0] m_op;
  int          m_rd, m_rs1, m_rs2, m_rs3;
  logic [NL-1:0] m_tmask;
  int unsigned m_pi, m_ph, m_pb;
  bit          last_fire;
  int          last_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int h_rd(input int w);  return int'(bus.ibuf_rd [RB*w +: RB]); endfunction
  function automatic int h_rs1(input int w); return int'(bus.ibuf_rs1[RB*w +: RB]); endfunction
  function automatic int h_rs2(input int w); return int'(bus.ibuf_rs2[RB*w +: RB]); endfunction
  function automatic int h_rs3(input int w); return int'(bus.ibuf_rs3[RB*w +: RB]); endfunction

  function automatic bit blocked(input int w);
    int regs [4];
    regs[0] = h_rd(w); regs[1] = h_rs1(w); regs[2] = h_rs2(w); regs[3] = h_rs3(w);
    foreach (regs[k]) if (regs[k] != 0 && m_pend[w][regs[k]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_pending();
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < (1 << RB); r++)
        if (m_pend[w][r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_select(output bit found, output bit fire, output int sel);
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < NW; k++) begin
      int w;
      w = (m_rr + k) % NW;
      if (!found && bus.ibuf_valid[w] && !blocked(w)) begin
        found = 1'b1;
        sel   = w;
      end
    end
    fire = found && (!m_iv || bus.issue_ready) && !reset;
  endfunction

  function automatic void model_update(input bit found, input bit fire, input int sel);
    if (reset) begin
      foreach (m_pend[w, r]) m_pend[w][r] = 1'b0;
      m_rr = 0; m_iv = 0; m_wid = 0; m_pc = '0; m_op = '0;
      m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_rs3 = 0; m_tmask = '0;
      m_pi = 0; m_ph = 0; m_pb = 0;
      return;
    end
    if (fire) m_pi++;
    if (bus.ibuf_valid != '0 && !found && (!m_iv || bus.issue_ready)) m_ph++;
    if (m_iv && !bus.issue_ready) m_pb++;
    if (bus.wb_valid && bus.wb_rd != '0) m_pend[bus.wb_wid][bus.wb_rd] = 1'b0;
    if (fire) begin
      if (h_rd(sel) != 0) m_pend[sel][h_rd(sel)] = 1'b1;
      m_wid = sel; m_pc = bus.ibuf_pc[AL*sel +: AL]; m_op = bus.ibuf_op[OB*sel +: OB];
      m_rd = h_rd(sel); m_rs1 = h_rs1(sel); m_rs2 = h_rs2(sel); m_rs3 = h_rs3(sel);
      m_tmask = bus.ibuf_tmask[NL*sel +: NL];
      m_iv = 1'b1;
      m_rr = (sel + 1) % NW;
    end else if (bus.issue_ready) begin
      m_iv = 1'b0;
    end
  endfunction

  // Inputs are driven while the clock is low; outputs are sampled on the falling edge.
  task automatic cycle();
    bit found, fire;
    int sel;
    logic [NW-1:0] exp_ready;
    #1;
    model_select(found, fire, sel);
    exp_ready = '0;
    if (fire) exp_ready[sel] = 1'b1;
    chk("ibuf_ready", bus.ibuf_ready, exp_ready);
    @(posedge clock);
    model_update(found, fire, sel);
    last_fire = fire;
    last_sel  = sel;
    @(negedge clock);
    chk("issue_valid", bus.issue_valid, m_iv);
    chk("sb_empty", bus.sb_empty, !any_pending());
    if (m_iv) begin
      chk("issue_wid", bus.issue_wid, m_wid);
      chk("issue_pc", bus.issue_pc, m_pc);
      chk("issue_op", bus.issue_op, m_op);
      chk("issue_regs", {bus.issue_rd, bus.issue_rs1, bus.issue_rs2, bus.issue_rs3},
          {m_rd[RB-1:0], m_rs1[RB-1:0], m_rs2[RB-1:0], m_rs3[RB-1:0]});
      chk("issue_tmask", bus.issue_tmask, m_tmask);
    end
`ifdef WARP_ISSUE_PERF_CTR_EN
    chk("perf_issued", bus.perf_issued, m_pi);
    chk("perf_hazard_stall", bus.perf_hazard_stall, m_ph);
    chk("perf_backpressure", bus.perf_backpressure, m_pb);
`endif
  endtask

  task automatic set_head(input int w, input logic [AL-1:0] pc, input int op, input int rd,
                          input int rs1, input int rs2, input int rs3, input logic [NL-1:0] tm);
    bus.ibuf_pc[AL*w +: AL]    = pc;
    bus.ibuf_op[OB*w +: OB]    = OB'(op);
    bus.ibuf_rd[RB*w +: RB]    = RB'(rd);
    bus.ibuf_rs1[RB*w +: RB]   = RB'(rs1);
    bus.ibuf_rs2[RB*w +: RB]   = RB'(rs2);
    bus.ibuf_rs3[RB*w +: RB]   = RB'(rs3);
    bus.ibuf_tmask[NL*w +: NL] = tm;
  endtask

  task automatic rand_head(input int w);
    set_head(w, AL'($urandom), int'($urandom_range(0, (1 << OB) - 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), NL'($urandom));
  endtask

  task automatic idle_all();
    bus.ibuf_valid = '0;
    for (int w = 0; w < NW; w++) set_head(w, '0, 0, 0, 0, 0, 0, '0);
    bus.wb_valid = 1'b0; bus.wb_wid = '0; bus.wb_rd = '0;
    bus.issue_ready = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  initial begin
    // Reset held three cycles with every head valid.
    idle_all();
    for (int w = 0; w < NW; w++) set_head(w, AL'(32'h1000 + 16 * w), w, 0, 0, 0, 0, 16'hffff);
    bus.ibuf_valid = '1;
    do_reset(3);
    chk("rst_pc", bus.issue_pc, 0);
    chk("rst_wid", bus.issue_wid, 0);
    chk("rst_tmask", bus.issue_tmask, 0);
    cycle();
    chk("first_valid", bus.issue_valid, 1);
    chk("first_wid", bus.issue_wid, 0);

    // Warps 0 and 3 alternate at full rate.
    do_reset(1);
    idle_all();
    set_head(0, 32'h100, 1, 0, 0, 0, 0, 16'h00ff);
    set_head(3, 32'h300, 3, 0, 0, 0, 0, 16'hff00);
    bus.ibuf_valid = 8'b0000_1001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_wid", bus.issue_wid, (k % 2 == 0) ? 0 : 3);
      chk("rr_sb_empty", bus.sb_empty, 1);
    end

    // RAW on warp 2 through r5, released by writeback.
    do_reset(1);
    idle_all();
    set_head(2, 32'h200, 2, 5, 0, 0, 0, 16'h0001);
    bus.ibuf_valid = 8'b0000_0100;
    cycle();
    set_head(2, 32'h204, 2, 0, 5, 0, 0, 16'h0003);
    cycle();
    chk("raw_sb_busy", bus.sb_empty, 0);
    cycle();
    chk("raw_blocked", bus.issue_valid, 0);
    bus.wb_valid = 1'b1; bus.wb_wid = 3'd2; bus.wb_rd = 8'd5;
    cycle();
    chk("raw_sb_clear", bus.sb_empty, 1);
    chk("raw_no_bypass", bus.issue_valid, 0);
    bus.wb_valid = 1'b0;
    cycle();
    chk("raw_issue", bus.issue_valid, 1);
    chk("raw_rs1", bus.issue_rs1, 5);

    // Backpressure holds the slot; the next warp loads on the ready cycle.
    do_reset(1);
    idle_all();
    set_head(0, 32'h8000_0010, 7, 0, 0, 0, 0, 16'h5555);
    bus.ibuf_valid = 8'b0000_0001;
    cycle();
    bus.issue_ready = 1'b0;
    bus.ibuf_valid = 8'b0000_0010;
    set_head(1, 32'h2000, 9, 0, 0, 0, 0, 16'haaaa);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("bp_pc", bus.issue_pc, 32'h8000_0010);
    end
    bus.issue_ready = 1'b1;
    cycle();
    chk("bp_next_wid", bus.issue_wid, 1);
    chk("bp_next_pc", bus.issue_pc, 32'h2000);

    // WAW on warp 1; another warp reading the same register number is independent.
    do_reset(1);
    idle_all();
    set_head(1, 32'h100, 1, 7, 0, 0, 0, 16'h000f);
    bus.ibuf_valid = 8'b0000_0010;
    cycle();
    set_head(1, 32'h104, 1, 7, 0, 0, 0, 16'h00f0);
    set_head(4, 32'h400, 4, 0, 0, 7, 0, 16'h0f00);
    bus.ibuf_valid = 8'b0001_0010;
    cycle();
    chk("waw_other_wid", bus.issue_wid, 4);
    bus.ibuf_valid = 8'b0000_0010;
    cycle();
    chk("waw_blocked", bus.issue_valid, 0);
    bus.wb_valid = 1'b1; bus.wb_wid = 3'd1; bus.wb_rd = 8'd7;
    cycle();
    bus.wb_valid = 1'b0;
    cycle();
    chk("waw_wid", bus.issue_wid, 1);
    chk("waw_pc", bus.issue_pc, 32'h104);

`ifdef WARP_ISSUE_PERF_CTR_EN
    // 10 issues, 4 backpressure cycles, then 5 hazard cycles.
    do_reset(1);
    idle_all();
    set_head(0, 32'h10, 1, 0, 0, 0, 0, 16'h1);
    bus.ibuf_valid = 8'b0000_0001;
    repeat (9) cycle();
    set_head(0, 32'h14, 1, 3, 0, 0, 0, 16'h1);
    cycle();
    set_head(0, 32'h18, 1, 0, 3, 0, 0, 16'h1);
    bus.issue_ready = 1'b0;
    repeat (4) cycle();
    bus.issue_ready = 1'b1;
    repeat (5) cycle();
    chk("perf_10", bus.perf_issued, 10);
    chk("perf_5", bus.perf_hazard_stall, 5);
    chk("perf_4", bus.perf_backpressure, 4);
`endif

    // Random traffic: heads change only when popped or idle.
    do_reset(1);
    idle_all();
    for (int w = 0; w < NW; w++) rand_head(w);
    bus.ibuf_valid = NW'($urandom);
    for (int n = 0; n < 300; n++) begin
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      bus.wb_valid    = ($urandom_range(0, 2) == 0);
      bus.wb_wid      = 3'($urandom_range(0, NW - 1));
      bus.wb_rd       = 8'($urandom_range(0, 7));
      cycle();
      for (int w = 0; w < NW; w++) begin
        if ((last_fire && last_sel == w) || !bus.ibuf_valid[w]) begin
          rand_head(w);
          bus.ibuf_valid[w] = ($urandom_range(0, 9) < 6);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/warp_issue_scoreboard.md
Name: warp_issue_scoreboard

Overview:
- Sits directly downstream of the Cyclotron frontend's per-warp instruction-buffer heads.
- Each cycle, selects at most one hazard-free warp head by round-robin and pops it via `ibuf_ready`.
- Registers the selected instruction into a single output stage toward the operand-collect/execute path.
- Tracks outstanding destination registers per warp in a scoreboard, cleared by the writeback port.

Parameters:
- ARCH_LEN, 32, PC width.
- NUM_WARPS, 8, number of warps; power of two, 2..32.
- NUM_LANES, 16, thread-mask width.
- OP_BITS, 9, opcode width (ext+base).
- REG_BITS, 8, register-address width; scoreboard depth per warp is 2**REG_BITS.
- WARP_ID_BITS, $clog2(NUM_WARPS), local, warp-id width.

Ports:
- clock  in  1  clock
- reset  in  1  reset
- ibuf_valid  in  NUM_WARPS  per-warp head valid
- ibuf_ready  out  NUM_WARPS  per-warp pop, one-hot or zero
- ibuf_pc  in  NUM_WARPS*ARCH_LEN  packed, warp w at [ARCH_LEN*w +: ARCH_LEN]
- ibuf_op  in  NUM_WARPS*OP_BITS  packed opcode
- ibuf_rd / ibuf_rs1 / ibuf_rs2 / ibuf_rs3  in  NUM_WARPS*REG_BITS each  packed register addresses
- ibuf_tmask  in  NUM_WARPS*NUM_LANES  packed thread masks
- issue_valid  out  1  output stage holds an instruction
- issue_ready  in  1  downstream accepts
- issue_wid  out  WARP_ID_BITS  issued warp
- issue_pc  out  ARCH_LEN
- issue_op  out  OP_BITS
- issue_rd / issue_rs1 / issue_rs2 / issue_rs3  out  REG_BITS each
- issue_tmask  out  NUM_LANES
- wb_valid  in  1  writeback completes
- wb_wid  in  WARP_ID_BITS  writeback warp
- wb_rd  in  REG_BITS  writeback register
- sb_empty  out  1  no pending register in any warp

Behaviour:
- Reset (synchronous, active-high, on clock rising edge):
  - Scoreboard cleared; RR pointer = 0.
  - issue_valid = 0; all issue_* payload = 0.
  - sb_empty = 1; ibuf_ready = 0 while reset is high.
- Register 0 is never tracked. rd==0 means no destination: it is never set, and source/dest fields equal to 0 never cause a hazard.
- Warp w is eligible when:
  - ibuf_valid[w] = 1, and
  - none of its nonzero rs1/rs2/rs3/rd has a pending bit (RAW + WAW) in the registered scoreboard.
  - There is no same-cycle writeback bypass.
- Output stage can load when issue_valid==0 or issue_ready==1.
- Selection: first eligible warp scanning from the RR pointer upward, with modulo-NUM_WARPS wrap.
- When the stage can load and a selection exists:
  - ibuf_ready[sel] = 1 combinationally; all other bits are 0.
  - Payload is registered on the edge; issue_valid = 1 next cycle.
  - RR pointer = sel+1 (wraps).
  - If rd != 0, scoreboard[sel][rd] is set.
- Otherwise:
  - ibuf_ready = 0 and the RR pointer is held.
  - If issue_ready==1 with no new load, issue_valid -> 0 next cycle; payload is held (don't-care).
- While issue_valid==1 && issue_ready==0, every issue_* output is stable.
- Latencies:
  - ibuf fire in cycle N -> issue_valid in N+1. Full throughput is 1/cycle.
  - Writeback in cycle N -> bit clear at end of N; the dependent warp is eligible in N+1 and issued in N+2.
- Writeback: wb_valid clears scoreboard[wb_wid][wb_rd].
  - wb_rd==0 is ignored.
  - Clearing a non-pending bit is a no-op.
  - Simultaneous set and clear on the same warp/register: set wins.
- sb_empty is registered: OR-reduction of the next scoreboard state, inverted.
- ibuf_ready must not depend on issue_valid of a different cycle other than through the stage-load condition (no comb loop via ibuf_valid -> ibuf_ready beyond the selection logic).

Optional Feature:
- Macro: WARP_ISSUE_PERF_CTR_EN.
- When defined, adds three outputs, all 32-bit, reset to 0, wrap on overflow:
  - perf_issued: ibuf fires.
  - perf_hazard_stall: cycles with some ibuf_valid, no eligible warp, and the stage able to load.
  - perf_backpressure: cycles with issue_valid && !issue_ready.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles with all ibuf_valid=1 -> ibuf_ready=0, issue_valid=0, sb_empty=1; first issue occurs the cycle after reset deasserts, from warp 0.
- Warps 0 and 3 valid continuously, all rd=0, issue_ready=1 -> issue_wid sequence 0,3,0,3 at one per cycle; sb_empty stays 1.
- Warp 2 head rd=5, next head rs1=5 -> first issues and sb_empty=0; second is blocked until wb_valid with wid=2, rd=5 in cycle N; second has issue_valid in N+2 and sb_empty returns to 1.
- issue_ready=0 for 4 cycles with pc=0x80000010 loaded -> issue_pc stable, ibuf_ready=0; on the ready cycle, the next warp loads the same edge (back-to-back).
- Warp 1 rd=7 pending and a new head with rd=7, rs*=0 -> blocked (WAW); warp 4 head rs2=7 is not blocked (different warp); wb for wid=1, rd=7 unblocks warp 1.
- With WARP_ISSUE_PERF_CTR_EN: 10 issues, 5 hazard cycles, 4 backpressure cycles -> counters read 10/5/4.
